sd_cmd_responder: RTL and testbench
===================================

Name: sd_cmd_responder

Overview:
- Card-side endpoint of the SD CMD line; the counterpart of the sdhc host command path.
- Deserializes 48-bit host commands, checks framing and CRC7, and presents them to local card logic.
- Serializes the 48-bit response that card logic supplies.
- Used for card emulation and as the bench-side device model for sdhc.
- Runs in the system clk domain and oversamples sd_clk edges.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on sd_clk and sd_cmd_in.
- NCR_MIN, 2: minimum sd_clk cycles between the command end bit and the response start bit.
- NCR_MAX, 64: sd_clk cycles to wait for resp_valid before abandoning the response.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sd_clk  input  1  SD bus clock from host, asynchronous to clk.
- sd_cmd_in  input  1  CMD line as sampled at the pad.
- sd_cmd_out  output  1  CMD drive value.
- sd_cmd_oe  output  1  1 = drive CMD, 0 = high-Z.
- cmd_valid  output  1  one-clk pulse: command captured.
- cmd_index  output  6  command index, held until the next cmd_valid.
- cmd_arg  output  32  command argument, held until the next cmd_valid.
- cmd_crc_err  output  1  one-clk pulse: CRC7 or framing error.
- resp_valid  input  1  card logic offers a response.
- resp_none  input  1  qualified by resp_valid; 1 = command has no response.
- resp_index  input  6  response bits [45:40].
- resp_arg  input  32  response bits [39:8].
- resp_ready  output  1  high in WAIT_RESP; a transfer occurs when resp_valid and resp_ready are both high.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync deassert by user): state=IDLE, sd_cmd_oe=0, sd_cmd_out=1, cmd_valid=0, cmd_crc_err=0, resp_ready=0, busy=0, cmd_index=0, cmd_arg=0, counters=0.
- Edge detection:
  - sd_clk and sd_cmd_in each pass through SYNC_STAGES flops.
  - rise = sync & ~prev; fall = ~sync & prev.
  - All bit sampling happens on rise. All output changes happen on fall.
- Frame format, MSB first: start 0, direction bit (host=1, card=0), index[5:0], arg[31:0], crc7[6:0], end 1.
- CRC7 uses polynomial x^7+x^3+1, initial value 0, computed over bits 47..8.
- IDLE: on rise with CMD=0, load the shift register, set bit count=1, go to RX.
- RX:
  - Shift on each rise; bit count is 6 bits wide.
  - On the 48th bit go to CHECK.
  - CMD is never driven in RX.
- CHECK (exactly one clk), with the captured frame F:
  - Error if F[46]!=1, F[0]!=1, or the CRC mismatches.
  - On error: pulse cmd_crc_err, go to IDLE.
  - On success: latch cmd_index and cmd_arg, pulse cmd_valid, clear the Ncr counter, go to WAIT_RESP.
  - cmd_valid is asserted 1 clk after the rise that samples the end bit.
- WAIT_RESP:
  - resp_ready=1. Count sd_clk rises.
  - Transfer with resp_none=1: go to IDLE.
  - Transfer with resp_none=0: latch the 48-bit frame {0,0,resp_index,resp_arg,crc7,1}, go to GAP.
  - If the count reaches NCR_MAX without a transfer: go to IDLE silently.
- GAP: wait until the Ncr counter reaches NCR_MIN rises, counted from the end bit and including rises seen in WAIT_RESP. Then go to TX.
- TX:
  - On the first fall: oe=1, out=bit47.
  - On each subsequent fall: shift the next bit.
  - After bit 0 (end bit 1) has been driven for one full sd_clk cycle, on the next fall: oe=0, out=1, go to IDLE.
- A new start bit seen during WAIT_RESP, GAP or TX is ignored; the host must wait for the response.
- Async reset mid-TX releases CMD (oe=0) immediately.
- If sd_clk stops, state is held indefinitely with no timeout in clk units.

Optional Feature:
- Macro SD_CMD_CRC_CHECK_EN.
- Defined: CRC7 is computed and checked as above. A mismatch yields a cmd_crc_err pulse, no cmd_valid, and no response.
- Undefined:
  - The CRC check is removed and only the direction and end bits are checked.
  - The received CRC field is ignored.
  - Response CRC7 is still generated.
  - The CRC contribution to cmd_crc_err is tied off.

Test Plan:
- Drive frame 0x400000000095 (CMD0, arg 0) at sd_clk=clk/8 -> one cmd_valid pulse, cmd_index=0, cmd_arg=0. Then resp_valid with resp_none=1 -> oe stays 0, return to IDLE.
- Drive 0x48000001AA87 (CMD8) -> cmd_index=8, cmd_arg=0x000001AA. Respond resp_index=8, resp_arg=0x000001AA -> 48 bits on CMD equal {0,0,8,0x1AA,crc7 per model,1}. The start bit appears at least NCR_MIN rises after the end bit. oe drops after the end bit.
- Drive 0x770000000065 (CMD55) with the CRC LSB flipped -> cmd_crc_err pulse and no cmd_valid with macro defined. Without the macro -> cmd_valid and cmd_index=55.
- Drive 0x400000000094 (CMD0 frame with end bit 0) -> cmd_crc_err pulse, back to IDLE. A following valid CMD0 is then accepted.
- After a valid CMD, never assert resp_valid -> after 64 sd_clk rises busy=0, CMD never driven. A subsequent command is accepted.
- Assert rst_n=0 at response bit 20 -> oe=0 and sd_cmd_out=1 in the same clk. After release, state is IDLE and the next CMD0 decodes correctly.

Source files
------------

// File: rtl/sd_cmd_responder_if.sv
// Card-logic side of the SD CMD responder: captured command out, response in.
// master = responder, slave = local card logic.
interface sd_cmd_responder_if;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_crc_err;
    logic        resp_valid;
    logic        resp_none;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        resp_ready;
    logic        busy;

    modport master (
        output cmd_valid, cmd_index, cmd_arg, cmd_crc_err, resp_ready, busy,
        input  resp_valid, resp_none, resp_index, resp_arg
    );

    modport slave (
        input  cmd_valid, cmd_index, cmd_arg, cmd_crc_err, resp_ready, busy,
        output resp_valid, resp_none, resp_index, resp_arg
    );
endinterface

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line endpoint: oversamples sd_clk, deserializes/validates host
// commands, serializes card responses. Define SD_CMD_CRC_CHECK_EN to check received CRC7.
module sd_cmd_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int NCR_MIN     = 2,
    parameter int NCR_MAX     = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sd_clk,
    input  logic                 sd_cmd_in,
    output logic                 sd_cmd_out,
    output logic                 sd_cmd_oe,
    sd_cmd_responder_if.master   card
);

    localparam int NCR_W = $clog2(NCR_MAX + 1);
    localparam logic [NCR_W-1:0] NCR_MIN_C = NCR_W'(NCR_MIN);
    localparam logic [NCR_W-1:0] NCR_MAX_C = NCR_W'(NCR_MAX);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RX    = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_TX    = 3'd5;

    // x^7 + x^3 + 1, zero seed, MSB first
    function automatic logic [6:0] crc7_calc(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb   = d[i] ^ c[6];
            c    = {c[5:0], 1'b0};
            c[0] = fb;
            c[3] = c[3] ^ fb;
        end
        return c;
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] cmd_sync_q;
    logic                   clk_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= '0;
            cmd_sync_q <= '1;
            clk_prev_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], sd_clk};
            cmd_sync_q <= {cmd_sync_q[SYNC_STAGES-2:0], sd_cmd_in};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk, scmd, rise, fall;
    assign sclk = clk_sync_q[SYNC_STAGES-1];
    assign scmd = cmd_sync_q[SYNC_STAGES-1];
    assign rise = sclk & ~clk_prev_q;
    assign fall = ~sclk & clk_prev_q;

    logic [2:0]       state_q, state_d;
    logic [47:0]      shreg_q, shreg_d;
    logic [5:0]       bcnt_q, bcnt_d;
    logic [NCR_W-1:0] ncr_q, ncr_d;
    logic             out_q, out_d;
    logic             oe_q, oe_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [5:0]       idx_q, idx_d;
    logic [31:0]      arg_q, arg_d;

    logic [47:0]      rx_frame;
    logic [47:0]      resp_frame;
    logic             crc_bad;
    logic             frame_bad;
    logic [NCR_W-1:0] ncr_inc;

    assign rx_frame = {shreg_q[46:0], scmd};

`ifdef SD_CMD_CRC_CHECK_EN
    assign crc_bad = (crc7_calc(rx_frame[47:8]) != rx_frame[7:1]);
`else
    assign crc_bad = 1'b0;
`endif

    assign frame_bad  = ~rx_frame[46] | ~rx_frame[0] | crc_bad;
    assign resp_frame = {2'b00, card.resp_index, card.resp_arg,
                         crc7_calc({2'b00, card.resp_index, card.resp_arg}), 1'b1};
    // Ncr saturates so a long GAP cannot wrap back below NCR_MIN
    assign ncr_inc    = (rise && ncr_q != NCR_MAX_C) ? ncr_q + 1'b1 : ncr_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        ncr_d   = ncr_q;
        out_d   = out_q;
        oe_d    = oe_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        idx_d   = idx_q;
        arg_d   = arg_q;
        case (state_q)
            S_IDLE: begin
                if (rise && !scmd) begin
                    shreg_d = 48'd0;
                    bcnt_d  = 6'd1;
                    state_d = S_RX;
                end
            end
            S_RX: begin
                if (rise) begin
                    shreg_d = rx_frame;
                    bcnt_d  = bcnt_q + 6'd1;
                    // pulses are registered here so they sit in the single CHECK clk
                    if (bcnt_q == 6'd47) begin
                        state_d = S_CHECK;
                        if (frame_bad) begin
                            err_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            idx_d   = rx_frame[45:40];
                            arg_d   = rx_frame[39:8];
                        end
                    end
                end
            end
            S_CHECK: begin
                ncr_d   = '0;
                state_d = err_q ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                ncr_d = ncr_inc;
                if (card.resp_valid) begin
                    if (card.resp_none) begin
                        state_d = S_IDLE;
                    end else begin
                        shreg_d = resp_frame;
                        bcnt_d  = 6'd0;
                        state_d = S_GAP;
                    end
                end else if (ncr_q >= NCR_MAX_C) begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                ncr_d = ncr_inc;
                if (ncr_q >= NCR_MIN_C) state_d = S_TX;
            end
            S_TX: begin
                if (fall) begin
                    // 48 bits already on the wire: the end bit has had its full cycle
                    if (bcnt_q == 6'd48) begin
                        oe_d    = 1'b0;
                        out_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        oe_d    = 1'b1;
                        out_d   = shreg_q[47];
                        shreg_d = {shreg_q[46:0], 1'b1};
                        bcnt_d  = bcnt_q + 6'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bcnt_q  <= '0;
            ncr_q   <= '0;
            out_q   <= 1'b1;
            oe_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            arg_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            ncr_q   <= ncr_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            arg_q   <= arg_d;
        end
    end

    assign sd_cmd_out       = out_q;
    assign sd_cmd_oe        = oe_q;
    assign card.cmd_valid   = valid_q;
    assign card.cmd_crc_err = err_q;
    assign card.cmd_index   = idx_q;
    assign card.cmd_arg     = arg_q;
    assign card.resp_ready  = (state_q == S_WAIT);
    assign card.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed + randomized bench for sd_cmd_responder; bench acts as SD host and card logic.
module tb_sd_cmd_responder;
    localparam int NCR_MIN = 2;
    localparam int NCR_MAX = 64;

    logic clk = 1'b0;
    logic sd_clk = 1'b0;
    logic rst_n;
    logic sd_cmd_in;
    logic sd_cmd_out, sd_cmd_oe;

    sd_cmd_responder_if card ();

    sd_cmd_responder #(.SYNC_STAGES(2), .NCR_MIN(NCR_MIN), .NCR_MAX(NCR_MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sd_clk     (sd_clk),
        .sd_cmd_in  (sd_cmd_in),
        .sd_cmd_out (sd_cmd_out),
        .sd_cmd_oe  (sd_cmd_oe),
        .card       (card)
    );

    always #5  clk = ~clk;
    always #40 sd_clk = ~sd_clk;   // sd_clk = clk/8

    int n_chk = 0;
    int n_pass = 0;
    int n_valid = 0, n_err = 0;
    logic [5:0]  seen_idx;
    logic [31:0] seen_arg;
    bit oe_seen = 0;
    int rise_cnt = 0, first_rise = 0, end_rise = 0;
    logic cap[$];

    always @(negedge clk) begin
        if (card.cmd_valid) begin
            n_valid++;
            seen_idx = card.cmd_index;
            seen_arg = card.cmd_arg;
        end
        if (card.cmd_crc_err) n_err++;
        if (sd_cmd_oe) oe_seen = 1;
    end

    // host samples CMD on sd_clk rises
    always @(posedge sd_clk) begin
        rise_cnt++;
        if (sd_cmd_oe) begin
            if (cap.size() == 0) first_rise = rise_cnt;
            cap.push_back(sd_cmd_out);
        end
    end

    // CRC7 by modulo-2 long division of d*x^7 by x^7+x^3+1
    function automatic logic [6:0] m_crc7(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'd0};
        for (int p = 46; p >= 7; p--)
            if (r[p]) r[p -: 8] = r[p -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [47:0] m_cmd(input logic [5:0] i, input logic [31:0] a);
        return {2'b01, i, a, m_crc7({2'b01, i, a}), 1'b1};
    endfunction

    function automatic logic [47:0] m_resp(input logic [5:0] i, input logic [31:0] a);
        return {2'b00, i, a, m_crc7({2'b00, i, a}), 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk);
            sd_cmd_in = f[i];
        end
        @(posedge sd_clk);
        #1 end_rise = rise_cnt;
        @(negedge sd_clk);
        sd_cmd_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // send a command and check the decode outcome against the model's verdict
    task automatic host_cmd(input string tag, input logic [47:0] f, input bit exp_ok);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_frame(f);
        chk({tag, "_valid"}, 48'(n_valid - v0), exp_ok ? 48'd1 : 48'd0);
        chk({tag, "_err"}, 48'(n_err - e0), exp_ok ? 48'd0 : 48'd1);
        if (exp_ok) begin
            chk({tag, "_idx"}, 48'(seen_idx), 48'(f[45:40]));
            chk({tag, "_arg"}, 48'(seen_arg), 48'(f[39:8]));
            chk({tag, "_ready"}, 48'(card.resp_ready), 48'd1);
        end else begin
            chk({tag, "_idle"}, 48'(card.busy), 48'd0);
        end
    endtask

    task automatic wait_idle(input string tag, input int max_clk);
        int k;
        k = 0;
        while (card.busy && k < max_clk) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle"}, 48'(card.busy), 48'd0);
    endtask

    task automatic give_resp(input bit none, input logic [5:0] i, input logic [31:0] a);
        @(negedge clk);
        card.resp_valid = 1'b1;
        card.resp_none  = none;
        card.resp_index = i;
        card.resp_arg   = a;
        @(negedge clk);
        card.resp_valid = 1'b0;
    endtask

    task automatic respond(input string tag, input bit none, input logic [5:0] i, input logic [31:0] a);
        logic [47:0] got;
        oe_seen = 0;
        cap.delete();
        give_resp(none, i, a);
        if (none) begin
            repeat (16) @(negedge clk);
            chk({tag, "_none_idle"}, 48'(card.busy), 48'd0);
            chk({tag, "_none_oe"}, 48'(oe_seen), 48'd0);
        end else begin
            wait_idle({tag, "_tx"}, 1200);
            repeat (2) @(negedge clk);
            got = '0;
            for (int b = 0; b < cap.size() && b < 48; b++) got = {got[46:0], cap[b]};
            chk({tag, "_nbits"}, 48'(cap.size()), 48'd48);
            chk({tag, "_frame"}, got, m_resp(i, a));
            chk({tag, "_ncr"}, 48'(first_rise - end_rise >= NCR_MIN), 48'd1);
            chk({tag, "_oe_off"}, {46'd0, sd_cmd_oe, sd_cmd_out}, 48'b01);
        end
    endtask

    initial begin
        logic [47:0] f;
        logic [5:0]  ri;
        logic [31:0] ra;
        bit          bad, exp_ok;
        int          k;

        rst_n = 1'b0;
        sd_cmd_in = 1'b1;
        card.resp_valid = 1'b0;
        card.resp_none  = 1'b0;
        card.resp_index = '0;
        card.resp_arg   = '0;
        repeat (4) @(negedge clk);
        chk("rst_oe_out", {46'd0, sd_cmd_oe, sd_cmd_out}, 48'b01);
        chk("rst_flags", {44'd0, card.cmd_valid, card.cmd_crc_err, card.resp_ready, card.busy}, 48'd0);
        chk("rst_idx_arg", {10'd0, card.cmd_index, card.cmd_arg}, 48'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        chk("model_cmd0", m_cmd(6'd0, 32'd0), 48'h400000000095);
        host_cmd("cmd0", 48'h400000000095, 1);
        respond("cmd0", 1, 6'd0, 32'd0);

        host_cmd("cmd8", 48'h48000001AA87, 1);
        respond("cmd8", 0, 6'd8, 32'h000001AA);

`ifdef SD_CMD_CRC_CHECK_EN
        host_cmd("cmd55_badcrc", 48'h770000000067, 0);
`else
        host_cmd("cmd55_badcrc", 48'h770000000067, 1);
        respond("cmd55", 1, 6'd0, 32'd0);
`endif

        host_cmd("cmd0_noend", 48'h400000000094, 0);
        host_cmd("cmd0_after", 48'h400000000095, 1);
        respond("cmd0_after", 1, 6'd0, 32'd0);

        // Ncr timeout: never answer
        oe_seen = 0;
        host_cmd("cmd_to", m_cmd(6'd17, 32'h1234), 1);
        repeat (56 * 8) @(negedge clk);
        chk("to_still_busy", 48'(card.busy), 48'd1);
        wait_idle("to", 300);
        chk("to_no_drive", 48'(oe_seen), 48'd0);
        host_cmd("cmd_after_to", m_cmd(6'd2, 32'd0), 1);
        respond("after_to", 1, 6'd0, 32'd0);

        // reset in the middle of a response
        host_cmd("cmd8_rst", 48'h48000001AA87, 1);
        cap.delete();
        give_resp(0, 6'd8, 32'h1AA);
        k = 0;
        while (cap.size() < 20 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_reached", 48'(cap.size() >= 20), 48'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_oe_out", {46'd0, sd_cmd_oe, sd_cmd_out}, 48'b01);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_idle", {46'd0, card.busy, card.resp_ready}, 48'd0);
        host_cmd("cmd0_post_rst", 48'h400000000095, 1);
        respond("post_rst", 1, 6'd0, 32'd0);

        // randomized commands vs reference model
        for (int n = 0; n < 8; n++) begin
            f = m_cmd(6'($urandom_range(0, 63)), $urandom);
            bad = ($urandom_range(0, 2) == 0);
            if (bad) f[$urandom_range(1, 7)] ^= 1'b1;
`ifdef SD_CMD_CRC_CHECK_EN
            exp_ok = !bad;
`else
            exp_ok = 1;
`endif
            host_cmd($sformatf("rnd%0d", n), f, exp_ok);
            if (exp_ok) begin
                ri = 6'($urandom_range(0, 63));
                ra = $urandom;
                respond($sformatf("rnd%0d", n), ($urandom_range(0, 3) == 0), ri, ra);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
